// File: rtl/midi_pkg.sv
// Shared types and helpers for the MIDI channel-voice parser: byte classes,
// status nibbles, event codes, FSM states and the message-length lookup.
package midi_pkg;

    localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
    localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
    localparam logic [3:0] NIB_POLY_AT  = 4'hA;
    localparam logic [3:0] NIB_CTRL     = 4'hB;
    localparam logic [3:0] NIB_PROG     = 4'hC;
    localparam logic [3:0] NIB_CHAN_AT  = 4'hD;
    localparam logic [3:0] NIB_PBEND    = 4'hE;

    typedef enum logic [1:0] {
        EVT_NOTE_OFF = 2'd0,
        EVT_NOTE_ON  = 2'd1,
        EVT_CC       = 2'd2,
        EVT_PBEND    = 2'd3
    } evt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        BC_DATA,
        BC_CHAN,
        BC_SYSEX_START,
        BC_SYSEX_END,
        BC_SYS_COMMON,
        BC_REALTIME
    } byte_class_t;

    function automatic byte_class_t classify(input logic [7:0] b);
        byte_class_t c;
        if (!b[7])             c = BC_DATA;
        else if (b < 8'hF0)    c = BC_CHAN;
        else if (b == 8'hF0)   c = BC_SYSEX_START;
        else if (b == 8'hF7)   c = BC_SYSEX_END;
        else if (b >= 8'hF8)   c = BC_REALTIME;
        else                   c = BC_SYS_COMMON;
        return c;
    endfunction

    // Program Change and Channel Pressure carry one data byte; the rest carry two.
    function automatic logic [1:0] msg_len(input logic [3:0] nib);
        return (nib == NIB_PROG || nib == NIB_CHAN_AT) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// Assembles MIDI channel-voice messages from a received byte stream with
// running status, emitting one-cycle Note/CC/Pitch-Bend event pulses.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_i,
    output logic       evt_valid_o,
    output logic [1:0] evt_type_o,
    output logic [3:0] evt_chan_o,
    output logic [6:0] evt_data1_o,
    output logic [6:0] evt_data2_o,
    output logic       running_o
);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_status, w_status_nxt;
    logic [6:0]  r_d1, w_d1_nxt;
    logic        r_running, w_running_nxt;

    logic        w_complete;
    logic [6:0]  w_msg_d1, w_msg_d2;
    byte_class_t w_class;

    logic        w_emit;
    evt_type_t   w_emit_type;
    logic        w_chan_ok;

    logic        r_evt_valid;
    evt_type_t   r_evt_type;
    logic [3:0]  r_evt_chan;
    logic [6:0]  r_evt_d1, r_evt_d2;

    assign w_class = classify(byte_i);

    // NOTE: every signal gets its default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt   = r_state;
        w_status_nxt  = r_status;
        w_d1_nxt      = r_d1;
        w_running_nxt = r_running;
        w_complete    = 1'b0;
        w_msg_d1      = 7'd0;
        w_msg_d2      = 7'd0;
        if (byte_valid_i) begin
            case (w_class)
                BC_CHAN: begin
                    w_status_nxt  = byte_i;
                    w_running_nxt = 1'b1;
                    w_state_nxt   = ST_WAIT_D1;
                end
                BC_SYSEX_START, BC_SYS_COMMON: begin
                    w_running_nxt = 1'b0;
                    w_state_nxt   = ST_DISCARD;
                end
                BC_SYSEX_END: begin
                    w_running_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
                BC_DATA: begin
                    case (r_state)
                        ST_WAIT_D1: begin
                            if (msg_len(r_status[7:4]) == 2'd2) begin
                                w_d1_nxt    = byte_i[6:0];
                                w_state_nxt = ST_WAIT_D2;
                            end else begin
                                w_complete = 1'b1;
                                w_msg_d1   = byte_i[6:0];
                            end
                        end
                        ST_WAIT_D2: begin
                            w_complete  = 1'b1;
                            w_msg_d1    = r_d1;
                            w_msg_d2    = byte_i[6:0];
                            w_state_nxt = ST_WAIT_D1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign w_chan_ok = OMNI || (r_status[3:0] == CHANNEL);

    always_comb begin
        w_emit      = 1'b0;
        w_emit_type = EVT_NOTE_OFF;
        case (r_status[7:4])
            NIB_NOTE_OFF: begin w_emit = 1'b1; w_emit_type = EVT_NOTE_OFF; end
            NIB_NOTE_ON: begin
                w_emit      = 1'b1;
                w_emit_type = (w_msg_d2 == 7'd0) ? EVT_NOTE_OFF : EVT_NOTE_ON;
            end
            NIB_CTRL:     begin w_emit = 1'b1; w_emit_type = EVT_CC;    end
            NIB_PBEND:    begin w_emit = 1'b1; w_emit_type = EVT_PBEND; end
            default: ;
        endcase
        w_emit = w_emit && w_complete && w_chan_ok;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_status    <= 8'd0;
            r_d1        <= 7'd0;
            r_running   <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_type  <= EVT_NOTE_OFF;
            r_evt_chan  <= 4'd0;
            r_evt_d1    <= 7'd0;
            r_evt_d2    <= 7'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_status    <= w_status_nxt;
            r_d1        <= w_d1_nxt;
            r_running   <= w_running_nxt;
            r_evt_valid <= w_emit;
            if (w_emit) begin
                r_evt_type <= w_emit_type;
                r_evt_chan <= r_status[3:0];
                r_evt_d1   <= w_msg_d1;
                r_evt_d2   <= w_msg_d2;
            end
        end
    end

    assign evt_valid_o = r_evt_valid;
    assign evt_type_o  = r_evt_type;
    assign evt_chan_o  = r_evt_chan;
    assign evt_data1_o = r_evt_d1;
    assign evt_data2_o = r_evt_d2;
    assign running_o   = r_running;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: an OMNI instance and a channel-3 instance share one
// byte stream and are compared every cycle against a queue-based message model.
module tb_midi_msg_parser;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [1:0] t;
        logic [3:0] c;
        logic [6:0] d1;
        logic [6:0] d2;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bv  = 1'b0;
    logic [7:0] bi  = 8'd0;

    logic       v0, v1, run0, run1;
    logic [1:0] t0, t1;
    logic [3:0] c0, c1;
    logic [6:0] a0, a1, b0, b1;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    bit chk_en  = 1'b0;

    // Model state: held status (-1 = none) and data bytes collected so far.
    int         m_status = -1;
    logic [6:0] m_data[$];
    bit         cfg_omni[2] = '{1'b1, 1'b0};
    logic [3:0] cfg_ch[2]   = '{4'd0, 4'd3};
    logic       e_v[2];
    logic [1:0] e_t[2];
    logic [3:0] e_c[2];
    logic [6:0] e_d1[2];
    logic [6:0] e_d2[2];
    ev_t        log_q[$];

    always #5 clk = ~clk;

    midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut0 (
        .clk_i(clk), .rst_i(rst), .byte_valid_i(bv), .byte_i(bi),
        .evt_valid_o(v0), .evt_type_o(t0), .evt_chan_o(c0),
        .evt_data1_o(a0), .evt_data2_o(b0), .running_o(run0)
    );

    midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd3)) dut1 (
        .clk_i(clk), .rst_i(rst), .byte_valid_i(bv), .byte_i(bi),
        .evt_valid_o(v1), .evt_type_o(t1), .evt_chan_o(c1),
        .evt_data1_o(a1), .evt_data2_o(b1), .running_o(run1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_emit(input int st, input logic [6:0] d1, input logic [6:0] d2);
        int         hi = st / 16;
        logic [3:0] ch = 4'(st % 16);
        logic [1:0] ty;
        ev_t        e;
        if (hi == 8)       ty = 2'd0;
        else if (hi == 9)  ty = (d2 == 7'd0) ? 2'd0 : 2'd1;
        else if (hi == 11) ty = 2'd2;
        else if (hi == 14) ty = 2'd3;
        else return;
        e = '{t: ty, c: ch, d1: d1, d2: d2};
        log_q.push_back(e);
        for (int k = 0; k < 2; k++) begin
            if (cfg_omni[k] || ch == cfg_ch[k]) begin
                e_v[k] = 1'b1; e_t[k] = ty; e_c[k] = ch; e_d1[k] = d1; e_d2[k] = d2;
            end
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int need;
        if (b >= 8'hF8) return;
        if (b >= 8'h80) begin
            m_status = (b < 8'hF0) ? int'(b) : -1;
            m_data.delete();
            return;
        end
        if (m_status < 0) return;
        m_data.push_back(b[6:0]);
        need = (m_status / 16 == 12 || m_status / 16 == 13) ? 1 : 2;
        if (m_data.size() == need) begin
            model_emit(m_status, m_data[0], (need == 2) ? m_data[1] : 7'd0);
            m_data.delete();
        end
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            e_v[k] = 1'b0; e_t[k] = 2'd0; e_c[k] = 4'd0; e_d1[k] = 7'd0; e_d2[k] = 7'd0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) e_v[k] = 1'b0;
            if (rst) begin
                m_status = -1;
                m_data.delete();
                for (int k = 0; k < 2; k++) begin
                    e_t[k] = 2'd0; e_c[k] = 4'd0; e_d1[k] = 7'd0; e_d2[k] = 7'd0;
                end
            end else if (bv) begin
                model_byte(bi);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (v0) pulses0++;
            if (v1) pulses1++;
            if (chk_en) begin
                check("dut0.valid", 32'(v0), 32'(e_v[0]));
                check("dut0.type",  32'(t0), 32'(e_t[0]));
                check("dut0.chan",  32'(c0), 32'(e_c[0]));
                check("dut0.data1", 32'(a0), 32'(e_d1[0]));
                check("dut0.data2", 32'(b0), 32'(e_d2[0]));
                check("dut0.running", 32'(run0), 32'(m_status >= 0));
                check("dut1.valid", 32'(v1), 32'(e_v[1]));
                check("dut1.type",  32'(t1), 32'(e_t[1]));
                check("dut1.chan",  32'(c1), 32'(e_c[1]));
                check("dut1.data1", 32'(a1), 32'(e_d1[1]));
                check("dut1.data2", 32'(b1), 32'(e_d2[1]));
                check("dut1.running", 32'(run1), 32'(m_status >= 0));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bv = 1'b1;
        bi = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bv = 1'b0;
        end
    endtask

    task automatic send_seq(input bq_t s, input int gap);
        foreach (s[i]) begin
            send(s[i]);
            if (gap > 0) idle(gap);
        end
        idle(3);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] coincident);
        @(negedge clk);
        rst = 1'b1;
        bv  = 1'b1;
        bi  = coincident;
        @(negedge clk);
        rst = 1'b0;
        bv  = 1'b0;
    endtask

    int base0, base1;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset.valid", 32'(v0), 32'd0);
        check("reset.running", 32'(run0), 32'd0);
        check("reset.data1", 32'(a0), 32'd0);

        // Basic Note On.
        base0 = pulses0;
        send_seq('{8'h90, 8'h3C, 8'h64}, 1);
        check("note_on.pulses", 32'(pulses0 - base0), 32'd1);
        check("note_on.type", 32'(t0), 32'd1);
        check("note_on.d1", 32'(a0), 32'h3C);
        check("model.note_on", {log_q[$].t, log_q[$].c, log_q[$].d1, log_q[$].d2},
              {2'd1, 4'd0, 7'h3C, 7'h64});

        // Running status with back-to-back strobes; velocity 0 becomes Note Off.
        base0 = pulses0;
        send_seq('{8'h91, 8'h40, 8'h50, 8'h41, 8'h00}, 0);
        check("running.pulses", 32'(pulses0 - base0), 32'd2);
        check("running.type", 32'(t0), 32'd0);
        check("running.chan", 32'(c0), 32'd1);
        check("model.running1", {log_q[$-1].t, log_q[$-1].c, log_q[$-1].d1, log_q[$-1].d2},
              {2'd1, 4'd1, 7'h40, 7'h50});
        check("model.running2", {log_q[$].t, log_q[$].c, log_q[$].d1, log_q[$].d2},
              {2'd0, 4'd1, 7'h41, 7'h00});

        // Real-Time bytes inside a CC message.
        base0 = pulses0;
        send_seq('{8'hB2, 8'hF8, 8'h07, 8'hFE, 8'h7F}, 0);
        check("rt.pulses", 32'(pulses0 - base0), 32'd1);
        check("rt.type", 32'(t0), 32'd2);
        check("rt.d2", 32'(a0 == 7'h07 && b0 == 7'h7F), 32'd1);
        check("rt.running", 32'(run0), 32'd1);

        // A new status aborts a partial Note On.
        base0 = pulses0;
        send_seq('{8'h90, 8'h3C, 8'hE0, 8'h00, 8'h40}, 1);
        check("abort.pulses", 32'(pulses0 - base0), 32'd1);
        check("abort.type", 32'(t0), 32'd3);
        check("abort.d2", 32'(b0), 32'h40);

        // SysEx consumed; trailing data byte ignored.
        base0 = pulses0;
        send_seq('{8'hF0}, 0);
        check("sysex.running", 32'(run0), 32'd0);
        send_seq('{8'h12, 8'h34, 8'hF7, 8'h45}, 0);
        check("sysex.pulses", 32'(pulses0 - base0), 32'd0);

        // Channel filter on dut1; 1-byte types never emit.
        base0 = pulses0; base1 = pulses1;
        send_seq('{8'h92, 8'h3C, 8'h64, 8'h93, 8'h3C, 8'h64}, 0);
        check("filter.pulses1", 32'(pulses1 - base1), 32'd1);
        check("filter.chan1", 32'(c1), 32'd3);
        check("filter.pulses0", 32'(pulses0 - base0), 32'd2);
        base0 = pulses0; base1 = pulses1;
        send_seq('{8'hC3, 8'h05, 8'h06, 8'hD3, 8'h11}, 0);
        check("prog.pulses", 32'(pulses0 - base0 + pulses1 - base1), 32'd0);
        check("prog.running", 32'(run1), 32'd1);

        // Running Pitch Bend on channel 3 after 1-byte types; System Common clears status.
        base1 = pulses1;
        send_seq('{8'hE3, 8'h01, 8'h02, 8'h7F, 8'h7F, 8'hF3, 8'h10, 8'h20}, 0);
        check("pbend.pulses1", 32'(pulses1 - base1), 32'd2);
        check("pbend.d1", 32'(a1), 32'h7F);
        check("syscommon.running", 32'(run1), 32'd0);

        // Reset mid-message, with strobes coincident with reset.
        base0 = pulses0;
        send_seq('{8'h90, 8'h3C}, 0);
        do_reset(8'h40);
        send_seq('{8'h40}, 0);
        check("rst_mid.pulses", 32'(pulses0 - base0), 32'd0);
        check("rst_mid.running", 32'(run0), 32'd0);
        check("rst_mid.valid", 32'(v0), 32'd0);
        base0 = pulses0;
        do_reset(8'h95);
        send_seq('{8'h40, 8'h41}, 0);
        check("rst_coinc.pulses", 32'(pulses0 - base0), 32'd0);
        check("rst_coinc.running", 32'(run0), 32'd0);
        check("rst_coinc.type", 32'(t0), 32'd0);

        idle(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
